// File: rtl/cpu_cu.sv
// Control-unit FSM for the CPU: fetch/decode/execute sequencing and execution-unit strobes.
// Optional single-step mode is enabled by defining CPU_CU_SINGLE_STEP_EN.
module cpu_cu #(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef CPU_CU_SINGLE_STEP_EN
  input  logic        step_i,
`endif
  input  logic [15:0] ir_i,
  input  logic        carry_i,
  input  logic        n_i,
  input  logic        z_i,
  output logic        adr_sel_o,
  output logic        s_sel_o,
  output logic        pc_ld_o,
  output logic        pc_inc_o,
  output logic        reg_w_en_o,
  output logic        ir_ld_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic        halted_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExAlu   = 3'd3,
    StExLoad  = 3'd4,
    StExStore = 3'd5,
    StExJmp   = 3'd6,
    StHalt    = 3'd7
  } state_e;

  localparam logic [2:0] LastWait = 3'(FETCH_WAIT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] flags_q, flags_d;  // {cf, nf, zf}
  logic       done;

  // Only the class field is decoded here; the rest belongs to the execution unit.
  logic unused_ir;
  assign unused_ir = ^{ir_i[15:12], ir_i[8:0]};

`ifdef CPU_CU_SINGLE_STEP_EN
  logic stalled_q, stalled_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      flags_q   <= '0;
`ifdef CPU_CU_SINGLE_STEP_EN
      stalled_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
`ifdef CPU_CU_SINGLE_STEP_EN
      stalled_q <= stalled_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    flags_d = flags_q;
    done    = 1'b0;
`ifdef CPU_CU_SINGLE_STEP_EN
    stalled_d = 1'b0;
    if (stalled_q) begin
      done = 1'b1;
    end else begin
`endif
      unique case (state_q)
        StIdle:  done = 1'b1;
        StFetch: begin
          if (cnt_q == LastWait) begin
            state_d = StDecode;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        StDecode: begin
          unique case (ir_i[11:9])
            3'b000: state_d = StExAlu;
            3'b001: state_d = StExLoad;
            3'b010: state_d = StExStore;
            3'b011: state_d = StExJmp;
            3'b100: if (flags_q[2]) state_d = StExJmp; else done = 1'b1;
            3'b101: if (flags_q[0]) state_d = StExJmp; else done = 1'b1;
            3'b110: if (flags_q[1]) state_d = StExJmp; else done = 1'b1;
            3'b111: state_d = StHalt;
          endcase
        end
        StExAlu: begin
          flags_d = {carry_i, n_i, z_i};
          done    = 1'b1;
        end
        StExLoad, StExStore, StExJmp: done = 1'b1;
        StHalt:  state_d = StHalt;
      endcase
`ifdef CPU_CU_SINGLE_STEP_EN
    end
    // Without a step request the FSM parks in its end-state, flagged as stalled.
    if (done) begin
      if (step_i) begin
        state_d = StFetch;
      end else begin
        state_d   = state_q;
        stalled_d = 1'b1;
      end
    end
`else
    if (done) state_d = StFetch;
`endif
  end

  always_comb begin
    adr_sel_o  = 1'b0;
    s_sel_o    = 1'b0;
    pc_ld_o    = 1'b0;
    pc_inc_o   = 1'b0;
    reg_w_en_o = 1'b0;
    ir_ld_o    = 1'b0;
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    halted_o   = 1'b0;
    unique case (state_q)
      StIdle, StDecode: ;
      StFetch: begin
        mem_cs_o = 1'b1;
        ir_ld_o  = (cnt_q == LastWait);
        pc_inc_o = (cnt_q == LastWait);
      end
      StExAlu: reg_w_en_o = 1'b1;
      StExLoad: begin
        adr_sel_o  = 1'b1;
        mem_cs_o   = 1'b1;
        s_sel_o    = 1'b1;
        reg_w_en_o = 1'b1;
      end
      StExStore: begin
        adr_sel_o = 1'b1;
        mem_cs_o  = 1'b1;
        mem_we_o  = 1'b1;
      end
      StExJmp: pc_ld_o  = 1'b1;
      StHalt:  halted_o = 1'b1;
    endcase
`ifdef CPU_CU_SINGLE_STEP_EN
    if (stalled_q) begin
      adr_sel_o  = 1'b0;
      s_sel_o    = 1'b0;
      pc_ld_o    = 1'b0;
      pc_inc_o   = 1'b0;
      reg_w_en_o = 1'b0;
      ir_ld_o    = 1'b0;
      mem_cs_o   = 1'b0;
      mem_we_o   = 1'b0;
      halted_o   = 1'b0;
    end
`endif
  end

`ifdef CPU_CU_SINGLE_STEP_EN
  assign state_o = stalled_q ? 3'd0 : state_q;
`else
  assign state_o = state_q;
`endif

endmodule

// File: tb/tb_cpu_cu.sv
// Self-checking bench for cpu_cu: per-cycle expected output vectors are queued with the
// stimulus and popped/compared at the falling edge. Instances with FETCH_WAIT=0 and 3.
module tb_cpu_cu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic        c, n, z, step;
    logic [11:0] exp;
  } ent_t;

  ent_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tname   = "";

  // DUT with FETCH_WAIT=0
  logic        rst0_n = 1'b0, step0 = 1'b1;
  logic [15:0] ir0 = '0;
  logic        c0 = 1'b0, n0 = 1'b0, z0 = 1'b0;
  logic        adr0, ssel0, pcld0, pcinc0, regw0, irld0, cs0, we0, hlt0;
  logic [2:0]  st0;
  logic [11:0] o0;
  assign o0 = {hlt0, st0, adr0, ssel0, pcld0, pcinc0, regw0, irld0, cs0, we0};

  cpu_cu #(.FETCH_WAIT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst0_n),
`ifdef CPU_CU_SINGLE_STEP_EN
    .step_i(step0),
`endif
    .ir_i(ir0), .carry_i(c0), .n_i(n0), .z_i(z0),
    .adr_sel_o(adr0), .s_sel_o(ssel0), .pc_ld_o(pcld0), .pc_inc_o(pcinc0),
    .reg_w_en_o(regw0), .ir_ld_o(irld0), .mem_cs_o(cs0), .mem_we_o(we0),
    .halted_o(hlt0), .state_o(st0)
  );

  // DUT with FETCH_WAIT=3
  logic        rst3_n = 1'b0, step3 = 1'b1;
  logic [15:0] ir3 = '0;
  logic        c3 = 1'b0, n3 = 1'b0, z3 = 1'b0;
  logic        adr3, ssel3, pcld3, pcinc3, regw3, irld3, cs3, we3, hlt3;
  logic [2:0]  st3;
  logic [11:0] o3;
  assign o3 = {hlt3, st3, adr3, ssel3, pcld3, pcinc3, regw3, irld3, cs3, we3};

  cpu_cu #(.FETCH_WAIT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n),
`ifdef CPU_CU_SINGLE_STEP_EN
    .step_i(step3),
`endif
    .ir_i(ir3), .carry_i(c3), .n_i(n3), .z_i(z3),
    .adr_sel_o(adr3), .s_sel_o(ssel3), .pc_ld_o(pcld3), .pc_inc_o(pcinc3),
    .reg_w_en_o(regw3), .ir_ld_o(irld3), .mem_cs_o(cs3), .mem_we_o(we3),
    .halted_o(hlt3), .state_o(st3)
  );

  // Expected {halted, state, adr_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld, mem_cs, mem_we}
  function automatic logic [11:0] model(input logic [2:0] st, input logic last);
    case (st)
      3'd1:    return {1'b0, st, 1'b0, 1'b0, 1'b0, last, 1'b0, last, 1'b1, 1'b0};
      3'd3:    return {1'b0, st, 8'b0000_1000};
      3'd4:    return {1'b0, st, 8'b1100_1010};
      3'd5:    return {1'b0, st, 8'b1000_0011};
      3'd6:    return {1'b0, st, 8'b0010_0000};
      3'd7:    return {1'b1, st, 8'b0000_0000};
      default: return {1'b0, st, 8'b0000_0000};
    endcase
  endfunction

  task automatic push(input logic [2:0] st, input logic last, input logic [15:0] ir,
                      input logic c, input logic n, input logic z, input logic step);
    ent_t e;
    e.ir = ir; e.c = c; e.n = n; e.z = z; e.step = step;
    e.exp = model(st, last);
    q.push_back(e);
  endtask

  task automatic drain(input bit use3);
    ent_t        e;
    logic [11:0] obs;
    int          cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      obs = use3 ? o3 : o0;
      n_tests++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h", tname, cyc, obs, e.exp);
      end
      n_tests++;
      if ((obs[5] & obs[4]) || (obs[0] & !(obs[1] & obs[7])) || (obs[3] & obs[0])) begin
        n_fail++;
        $display("FAIL %s invariant cycle %0d: got %h want strobe invariants held", tname,
                 cyc, obs);
      end
      if (use3) begin
        ir3 = e.ir; c3 = e.c; n3 = e.n; z3 = e.z; step3 = e.step;
      end else begin
        ir0 = e.ir; c0 = e.c; n0 = e.n; z0 = e.z; step0 = e.step;
      end
      cyc++;
    end
  endtask

  // Reset dut0 and release it on a falling edge so the next cycle is FETCH.
  task automatic reset0();
    rst0_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o0 !== 12'h000) begin
      n_fail++;
      $display("FAIL %s reset: got %h want %h", tname, o0, 12'h000);
    end
    rst0_n = 1'b1;
    ir0 = '0; c0 = 1'b0; n0 = 1'b0; z0 = 1'b0; step0 = 1'b1;
  endtask

  // Queue one full FETCH(0 wait)/DECODE pair for dut0.
  task automatic fd(input logic [15:0] ir, input logic c);
    push(3'd1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd2, 1'b0, ir, c, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    tname = "reset_alu";
    reset0();
    fd(16'h0000, 1'b0);
    push(3'd3, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);  // latch cf=1
    drain(1'b0);
  endtask

  task automatic test_cond_jump();
    tname = "cond_jump";
    fd(16'h0800, 1'b0);                                // cf=1 latched, live carry 0
    push(3'd6, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fd(16'h0000, 1'b0);
    push(3'd3, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);  // cf=0 nf=0 zf=1
    fd(16'h0800, 1'b1);                                // untaken despite live carry
    fd(16'h0A00, 1'b0);                                // zf taken
    push(3'd6, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fd(16'h0C00, 1'b0);                                // nf untaken
    drain(1'b0);
  endtask

  task automatic test_store_load();
    tname = "store_load";
    fd(16'h0400, 1'b0);
    push(3'd5, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fd(16'h0200, 1'b0);
    push(3'd4, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    fd(16'h0600, 1'b0);                                // unconditional jump
    push(3'd6, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_wait_states();
    tname = "wait_states";
    rst3_n = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    for (int i = 0; i < 4; i++) push(3'd1, (i == 3), 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd3, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(1'b1);
  endtask

  task automatic test_halt();
    tname = "halt";
    fd(16'h0E00, 1'b0);
    for (int i = 0; i < 20; i++) push(3'd7, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    reset0();
    fd(16'h0000, 1'b0);
    push(3'd3, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);  // cf=1 before the reset
    fd(16'h0200, 1'b0);
    push(3'd4, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(1'b0);
    rst0_n = 1'b0;
    #1;
    n_tests++;
    if (o0 !== 12'h000) begin
      n_fail++;
      $display("FAIL %s async_clear: got %h want %h", tname, o0, 12'h000);
    end
    @(negedge clk);
    rst0_n = 1'b1;
    fd(16'h0800, 1'b1);                                // flags cleared: untaken
    push(3'd1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(1'b0);
  endtask

`ifdef CPU_CU_SINGLE_STEP_EN
  task automatic test_single_step();
    tname = "single_step";
    reset0();
    step0 = 1'b0;
    for (int i = 0; i < 3; i++) push(3'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);  // one-cycle step pulse
    push(3'd1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(3'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
    step0 = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_cond_jump();
    test_store_load();
    test_wait_states();
    test_halt();
    test_reset_mid();
`ifdef CPU_CU_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
